// File: rtl/cic_interp_third_stage_if.sv
// ---------------------------------------------------------------------------
// cic_interp_third_stage_if
//   Sample-stream bundle for the CIC interpolator.
//   Low-rate input side : x_in / x_valid (source -> block), x_ready (block -> source)
//   High-rate output    : y_out / y_valid (block -> DAC-rate datapath)
//   modport master : the baseband source / consumer side (testbench)
//   modport slave  : the interpolator itself
// ---------------------------------------------------------------------------
interface cic_interp_third_stage_if #(
  parameter int IN_W = 16
);
  logic signed [IN_W-1:0] x_in;
  logic                   x_valid;
  logic                   x_ready;
  logic signed [IN_W-1:0] y_out;
  logic                   y_valid;

  modport master (
    output x_in,
    output x_valid,
    input  x_ready,
    input  y_out,
    input  y_valid
  );

  modport slave (
    input  x_in,
    input  x_valid,
    output x_ready,
    output y_out,
    output y_valid
  );
endinterface

// File: rtl/cic_interp_third_stage.sv
// ---------------------------------------------------------------------------
// cic_interp_third_stage
//   3-stage CIC interpolator (M=1). Low-rate Q1.15 samples are taken through a
//   valid/ready handshake once every L = 2^k enabled cycles, run through three
//   comb stages, zero-stuffed and integrated by three accumulators at the high
//   rate, then scaled by 2^-2k (DC gain 1) and saturated to Q1.15.
//
// Ports
//   clk, reset          sole clock; synchronous active-high reset (clears all)
//   clk_enable          high-rate cycle qualifier
//   sample_if (slave)   x_in/x_valid/x_ready input, y_out/y_valid output
//   ctrl_enable         path enable; a rising edge re-latches k
//   ctrl_reset          synchronous flush, same effect as reset
//   ctrl_interp_sel     k request, values above 4 clamp to 4
//   ce_out              registered clk_enable & ctrl_enable
//   status_L_active     latched k
//   status_underflow    sticky: take slot with no x_valid
//   status_overflow     sticky: output saturated
//   status_ready        pipeline primed (first y_valid seen)
//
// Build option
//   CIC_INTERP_ROUND_EN defined  : round-half-up before the 2k-bit shift
//   CIC_INTERP_ROUND_EN undefined: truncate (floor)
// ---------------------------------------------------------------------------
module cic_interp_third_stage #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 28
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_enable,
  cic_interp_third_stage_if.slave sample_if,
  input  logic                    ctrl_enable,
  input  logic                    ctrl_reset,
  input  logic [7:0]              ctrl_interp_sel,
  output logic                    ce_out,
  output logic [7:0]              status_L_active,
  output logic                    status_underflow,
  output logic                    status_overflow,
  output logic                    status_ready
);

  localparam logic [2:0] K_MAX = 3'd4;
  localparam logic signed [ACC_W:0] S_MAX = {{(ACC_W-IN_W+2){1'b0}}, {(IN_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] S_MIN = {{(ACC_W-IN_W+2){1'b1}}, {(IN_W-1){1'b0}}};

  function automatic logic [2:0] clamp_k(input logic [7:0] sel);
    if (sel > {5'd0, K_MAX}) return K_MAX;
    return sel[2:0];
  endfunction

  // One extra bit of headroom so the rounding constant can never wrap I3.
  function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] acc,
                                                        input logic [2:0]              k);
    logic signed [ACC_W:0] ext;
    ext = {acc[ACC_W-1], acc};
`ifdef CIC_INTERP_ROUND_EN
    if (k != 3'd0)
      ext = ext + $signed({{ACC_W{1'b0}}, 1'b1} << ({1'b0, k, 1'b0} - 5'd1));
`endif
    return ext >>> {k, 1'b0};
  endfunction

  function automatic logic signed [IN_W-1:0] saturate(input logic signed [ACC_W:0] s);
    if (s > S_MAX) return S_MAX[IN_W-1:0];
    if (s < S_MIN) return S_MIN[IN_W-1:0];
    return s[IN_W-1:0];
  endfunction

  logic                    flush;
  logic                    step;
  logic                    take;
  logic [2:0]              k_act;
  logic                    en_q;
  logic [3:0]              phase;
  logic [3:0]              last_phase;
  logic [2:0]              prime_cnt;

  logic signed [ACC_W-1:0] x_feed;
  logic signed [ACC_W-1:0] c1;
  logic signed [ACC_W-1:0] c2;
  logic signed [ACC_W-1:0] c3;
  logic signed [ACC_W-1:0] d1_p0;
  logic signed [ACC_W-1:0] d2_p0;
  logic signed [ACC_W-1:0] d3_p0;
  logic signed [ACC_W-1:0] c_reg;
  logic                    vld_p0;
  logic signed [ACC_W-1:0] integ_in;
  logic signed [ACC_W-1:0] i1_p1;
  logic signed [ACC_W-1:0] i2_p2;
  logic signed [ACC_W-1:0] i3_p3;
  logic signed [ACC_W:0]   scaled;
  logic                    sat_hit;
  logic signed [IN_W-1:0]  y_p4;
  logic                    vld_p4;

  assign flush      = reset | ctrl_reset;
  assign step       = clk_enable & ctrl_enable;
  assign take       = step & (phase == 4'd0);
  assign last_phase = 4'((5'd1 << k_act) - 5'd1);

  // A flush on the same edge as an accept wins, so ready is withheld then.
  assign sample_if.x_ready = take & ~flush;
  assign sample_if.y_out   = y_p4;
  assign sample_if.y_valid = vld_p4;
  assign status_L_active   = {5'd0, k_act};

  always_comb begin
    x_feed = '0;
    if (sample_if.x_valid)
      x_feed = {{(ACC_W-IN_W){sample_if.x_in[IN_W-1]}}, sample_if.x_in};
    c1       = x_feed - d1_p0;
    c2       = c1 - d2_p0;
    c3       = c2 - d3_p0;
    // Zero-stuffing: the comb result feeds the integrators for one step only.
    integ_in = vld_p0 ? c_reg : '0;
    scaled   = round_shift(i3_p3, k_act);
    sat_hit  = (scaled > S_MAX) || (scaled < S_MIN);
  end

  // Control: rate, phase, priming and status
  always_ff @(posedge clk) begin
    en_q <= ctrl_enable;
    if (flush) begin
      k_act            <= clamp_k(ctrl_interp_sel);
      phase            <= '0;
      vld_p0           <= 1'b0;
      prime_cnt        <= '0;
      vld_p4           <= 1'b0;
      ce_out           <= 1'b0;
      status_ready     <= 1'b0;
      status_underflow <= 1'b0;
      status_overflow  <= 1'b0;
    end else begin
      ce_out <= step;
      if (ctrl_enable && !en_q)
        k_act <= clamp_k(ctrl_interp_sel);
      if (step) begin
        // >= rather than == so a k change without flush still re-enters 0..L-1
        phase  <= (phase >= last_phase) ? 4'd0 : phase + 4'd1;
        vld_p0 <= take;
        if (take && !sample_if.x_valid)
          status_underflow <= 1'b1;
        if (sat_hit)
          status_overflow <= 1'b1;
        // Counts 1..5 from the first take slot; output valid from the 5th step on.
        if (prime_cnt == 3'd0) begin
          if (take) prime_cnt <= 3'd1;
        end else if (prime_cnt != 3'd5) begin
          prime_cnt <= prime_cnt + 3'd1;
        end
        vld_p4 <= (prime_cnt >= 3'd4);
        if (prime_cnt >= 3'd4)
          status_ready <= 1'b1;
      end
    end
  end

  // Datapath: comb (p0) -> integrators (p1..p3) -> scale/saturate (p4)
  always_ff @(posedge clk) begin
    if (flush) begin
      d1_p0 <= '0;
      d2_p0 <= '0;
      d3_p0 <= '0;
      c_reg <= '0;
      i1_p1 <= '0;
      i2_p2 <= '0;
      i3_p3 <= '0;
      y_p4  <= '0;
    end else if (step) begin
      // p0: comb stages advance at the low rate only
      if (take) begin
        d1_p0 <= x_feed;
        d2_p0 <= c1;
        d3_p0 <= c2;
        c_reg <= c3;
      end
      // p1..p3: integrators, intentional two's-complement wrap
      i1_p1 <= i1_p1 + integ_in;
      i2_p2 <= i2_p2 + i1_p1;
      i3_p3 <= i3_p3 + i2_p2;
      // p4: normalize by L^2 and clamp to Q1.15
      y_p4  <= saturate(scaled);
    end
  end

endmodule

// File: tb/tb_cic_interp_third_stage.sv
`timescale 1ns/1ps
module tb_cic_interp_third_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_enable;
  logic       ctrl_enable;
  logic       ctrl_reset;
  logic [7:0] ctrl_interp_sel;
  logic       ce_out;
  logic [7:0] status_L_active;
  logic       status_underflow;
  logic       status_overflow;
  logic       status_ready;

  always #5 clk = ~clk;

  cic_interp_third_stage_if #(.IN_W(16)) bus ();

  cic_interp_third_stage #(.IN_W(16), .ACC_W(28)) dut (
    .clk              (clk),
    .reset            (reset),
    .clk_enable       (clk_enable),
    .sample_if        (bus),
    .ctrl_enable      (ctrl_enable),
    .ctrl_reset       (ctrl_reset),
    .ctrl_interp_sel  (ctrl_interp_sel),
    .ce_out           (ce_out),
    .status_L_active  (status_L_active),
    .status_underflow (status_underflow),
    .status_overflow  (status_overflow),
    .status_ready     (status_ready)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: output = (zero-stuffed input) * (length-L boxcar)^3 / L^2,
  // delayed so that a sample taken at step T shows up after the 5th step.
  int     n_steps;
  int     k_m;
  int     l_m;
  longint u [0:4095];
  longint h [0:63];
  longint y_m;
  bit     uf_m;
  bit     ov_m;

  typedef struct {
    int sel;
    int x;
    int y_exp;
    int l_exp;
  } dc_vec_t;

  dc_vec_t dc_tab [6];

  task automatic chk(input string nm, input longint act, input longint exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      if (fails <= 25)
        $display("FAIL %s: got %0d, expected %0d (step %0d)", nm, act, exp_v, n_steps);
    end
  endtask

  task automatic build_h();
    longint b2 [0:63];
    for (int i = 0; i < 64; i++) begin
      b2[i] = 0;
      h[i]  = 0;
    end
    for (int i = 0; i < l_m; i++)
      for (int j = 0; j < l_m; j++)
        b2[i+j] += 1;
    for (int i = 0; i < 2*l_m-1; i++)
      for (int j = 0; j < l_m; j++)
        h[i+j] += b2[i];
  endtask

  function automatic longint model_scale(longint acc);
    longint r;
    r = 0;
`ifdef CIC_INTERP_ROUND_EN
    if (k_m > 0) r = longint'(1) << (2*k_m - 1);
`endif
    return (acc + r) >>> (2*k_m);
  endfunction

  task automatic update_y();
    longint acc;
    longint pre;
    acc = 0;
    for (int j = 0; j < 3*l_m-2; j++) begin
      int idx;
      idx = n_steps - 5 - j;
      if (idx >= 0) acc += h[j] * u[idx];
    end
    pre = model_scale(acc);
    if (pre > 32767) begin
      y_m  = 32767;
      ov_m = 1'b1;
    end else if (pre < -32768) begin
      y_m  = -32768;
      ov_m = 1'b1;
    end else begin
      y_m = pre;
    end
  endtask

  task automatic check_outputs(input bit ce_exp);
    chk("y_out",            $signed(bus.y_out), y_m);
    chk("y_valid",          bus.y_valid,        n_steps >= 5);
    chk("status_ready",     status_ready,       n_steps >= 5);
    chk("status_underflow", status_underflow,   uf_m);
    chk("status_overflow",  status_overflow,    ov_m);
    chk("status_L_active",  status_L_active,    k_m);
    chk("ce_out",           ce_out,             ce_exp);
  endtask

  // One clock: drive inputs, check x_ready, clock, advance model, check outputs.
  task automatic cyc(input bit ce, input bit en, input bit xv, input logic signed [15:0] x);
    bit take;
    clk_enable  = ce;
    ctrl_enable = en;
    bus.x_valid = xv;
    bus.x_in    = x;
    #1;
    take = ce && en && ((n_steps % l_m) == 0);
    chk("x_ready", bus.x_ready, take);
    @(posedge clk);
    #1;
    if (ce && en) begin
      u[n_steps] = (take && xv) ? longint'(x) : 0;
      if (take && !xv) uf_m = 1'b1;
      n_steps++;
      update_y();
    end
    check_outputs(ce && en);
  endtask

  task automatic do_flush(input int sel, input bit use_ctrl);
    ctrl_interp_sel = 8'(sel);
    clk_enable      = 1'b1;
    ctrl_enable     = 1'b1;
    bus.x_valid     = 1'b1;
    bus.x_in        = 16'sh1234;
    if (use_ctrl) ctrl_reset = 1'b1;
    else          reset      = 1'b1;
    #1;
    chk("x_ready_during_flush", bus.x_ready, 0);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    ctrl_reset = 1'b0;
    n_steps = 0;
    uf_m    = 1'b0;
    ov_m    = 1'b0;
    y_m     = 0;
    k_m     = (sel > 4) ? 4 : sel;
    l_m     = 1 << k_m;
    build_h();
    check_outputs(1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint imp_exp [0:9];
`ifdef CIC_INTERP_ROUND_EN
    imp_exp = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
`else
    imp_exp = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
    dc_tab[0] = '{sel: 0, x:   1234, y_exp:   1234, l_exp: 0};
    dc_tab[1] = '{sel: 1, x:  -5000, y_exp:  -5000, l_exp: 1};
    dc_tab[2] = '{sel: 2, x: 'h2000, y_exp: 'h2000, l_exp: 2};
    dc_tab[3] = '{sel: 3, x:   -100, y_exp:   -100, l_exp: 3};
    dc_tab[4] = '{sel: 4, x: -32768, y_exp: -32768, l_exp: 4};
    dc_tab[5] = '{sel: 9, x:  32767, y_exp:  32767, l_exp: 4};

    reset           = 1'b1;
    ctrl_reset      = 1'b0;
    clk_enable      = 1'b0;
    ctrl_enable     = 1'b0;
    ctrl_interp_sel = 8'd0;
    bus.x_valid     = 1'b0;
    bus.x_in        = '0;
    n_steps         = 0;
    k_m             = 0;
    l_m             = 1;
    @(posedge clk);
    #1;

    // Reset values
    do_flush(2, 1'b0);

    // DC gain and clamped selection, table driven
    for (int v = 0; v < 6; v++) begin
      do_flush(dc_tab[v].sel, 1'b0);
      chk("dc_L_active", status_L_active, dc_tab[v].l_exp);
      for (int i = 0; i < 3*l_m + 8; i++)
        cyc(1'b1, 1'b1, 1'b1, 16'(dc_tab[v].x));
      chk("dc_settled",  $signed(bus.y_out), dc_tab[v].y_exp);
      chk("dc_no_ovf",   status_overflow, 0);
    end

    // L=1 ramp: plain 5-step delay
    do_flush(0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 16'(-32 + i));
      if (n_steps >= 5) chk("ramp_delay", $signed(bus.y_out), -32 + (n_steps - 5));
    end

    // L=4 impulse response
    do_flush(2, 1'b1);
    for (int i = 0; i < 14; i++) begin
      cyc(1'b1, 1'b1, 1'b1, (i == 0) ? 16'sd1 : 16'sd0);
      if (n_steps >= 5) chk("impulse", $signed(bus.y_out), imp_exp[n_steps-5]);
    end

    // L=16 full-scale negative DC, then one missing sample
    do_flush(4, 1'b0);
    for (int i = 0; i < 60; i++) cyc(1'b1, 1'b1, 1'b1, -16'sd32768);
    chk("neg_full_scale", $signed(bus.y_out), -32768);
    chk("neg_no_uf", status_underflow, 0);
    for (int i = 0; i < 16 && (n_steps % 16) != 0; i++) cyc(1'b1, 1'b1, 1'b1, -16'sd32768);
    cyc(1'b1, 1'b1, 1'b0, -16'sd32768);
    chk("uf_set", status_underflow, 1);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b1, -16'sd32768);
    chk("uf_sticky", status_underflow, 1);

    // Selection changes while enabled are ignored until an enable rising edge
    do_flush(2, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b1, 16'sd500);
    ctrl_interp_sel = 8'd4;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 16'sd500);
    chk("sel_ignored", status_L_active, 2);
    cyc(1'b1, 1'b0, 1'b1, 16'sd500);
    ctrl_enable = 1'b1;
    clk_enable  = 1'b0;
    @(posedge clk);
    #1;
    chk("sel_relatched", status_L_active, 4);

    // Switching L=16 -> L=1 without flush leaves I3 at 256x full scale: saturates
    do_flush(4, 1'b0);
    for (int i = 0; i < 70; i++) cyc(1'b1, 1'b1, 1'b1, 16'sd32767);
    chk("pos_full_scale", $signed(bus.y_out), 32767);
    chk("pos_no_ovf", status_overflow, 0);
    ctrl_interp_sel = 8'd0;
    cyc(1'b1, 1'b0, 1'b1, 16'sd32767);
    ctrl_enable = 1'b1;
    clk_enable  = 1'b0;
    @(posedge clk);
    #1;
    chk("ovf_L_active", status_L_active, 0);
    clk_enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
    end
    chk("ovf_sat_value", $signed(bus.y_out), 32767);
    chk("ovf_flag", status_overflow, 1);

    // ctrl_reset mid-stream at L=8 and restart priming
    do_flush(3, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b1, 16'sd1000);
    do_flush(3, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 16'sd1000);
      if (n_steps == 4) chk("restart_not_primed", bus.y_valid, 0);
      if (n_steps == 5) chk("restart_primed", bus.y_valid, 1);
    end

    // Randomized streams with stalls, enable drops and missing samples
    for (int seg = 0; seg < 6; seg++) begin
      do_flush(int'($urandom_range(0, 6)), seg[0]);
      for (int i = 0; i < 160; i++)
        cyc($urandom_range(0, 4) != 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 11) != 0, 16'($urandom()));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
